// File: rtl/add_ctrl_pkg.sv
// Shared FSM encoding, default sizes and ID-width helper for the round-robin adder controller.
package add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 2;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_2bit_rr_ctrl_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping to 0.
// Zero latency; no flow control of its own.
module rr_pick
  import add_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    winner,
  output logic [NUM_REQ-1:0] onehot
);

  int              idx;
  logic [ID_W-1:0] cand;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Wrap explicitly so NUM_REQ need not be a power of two.
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
    if (any) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/add_2bit_rr_ctrl.sv
// Shares one registered adder among NUM_REQ requesters via round-robin; grant at the request edge,
// response valid one edge later and held until rsp_ready_in is seen high on a clock edge.
module add_2bit_rr_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  WIDTH   = DEF_WIDTH,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt_out,
  output logic [WIDTH-1:0]         sum_out,
  output logic                     carry_out,
  output logic [ID_W-1:0]          rsp_id_out,
  output logic                     rsp_valid_out,
  input  logic                     rsp_ready_in,
  output logic                     busy_out
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    win_q;
  logic [WIDTH-1:0]   a_cap, b_cap;
  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];
  logic               pick_any;
  logic [ID_W-1:0]    pick_win;
  logic [NUM_REQ-1:0] pick_onehot;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
    assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req_in),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_win),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = pick_any ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    state_d = rsp_ready_in ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  assign busy_out = (state_q != IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gnt_out       <= '0;
      a_cap         <= '0;
      b_cap         <= '0;
      win_q         <= '0;
      ptr_q         <= '0;
      sum_out       <= '0;
      carry_out     <= 1'b0;
      rsp_id_out    <= '0;
      rsp_valid_out <= 1'b0;
    end else begin
      gnt_out <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_out <= pick_onehot;
            a_cap   <= a_arr[pick_win];
            b_cap   <= b_arr[pick_win];
            win_q   <= pick_win;
          end
        end
        EXEC: begin
          {carry_out, sum_out} <= {1'b0, a_cap} + {1'b0, b_cap};
          rsp_id_out           <= win_q;
          rsp_valid_out        <= 1'b1;
        end
        RESP: begin
          // Pointer moves past the winner only once its response is consumed.
          if (rsp_ready_in) begin
            rsp_valid_out <= 1'b0;
            ptr_q         <= (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_2bit_rr_ctrl.sv
// Self-checking bench for add_2bit_rr_ctrl: directed scenarios plus randomized ops against a
// transaction-level round-robin/adder model.
module tb_add_2bit_rr_ctrl;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_bus = '0;
  logic [N*W-1:0] b_bus = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   sum;
  logic           carry;
  logic [IW-1:0]  rsp_id;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  add_2bit_rr_ctrl #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_in        (req),
    .a_in          (a_bus),
    .b_in          (b_bus),
    .gnt_out       (gnt),
    .sum_out       (sum),
    .carry_out     (carry),
    .rsp_id_out    (rsp_id),
    .rsp_valid_out (rsp_valid),
    .rsp_ready_in  (rsp_ready),
    .busy_out      (busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: first pending requester counting upward from p, modulo N.
  function automatic int rr_winner(input logic [N-1:0] r, input int p);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = r >> ((p + i) % N);
      if (t[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] op_of(input logic [N*W-1:0] bus, input int i);
    logic [N*W-1:0] t;
    t = bus >> (i * W);
    return t[W-1:0];
  endfunction

  // Expected {valid, id, carry, sum} for requester w adding x + y.
  function automatic logic [IW+W+1:0] exp_rsp(input int w, input logic [W-1:0] x, input logic [W-1:0] y);
    int s;
    s = int'(x) + int'(y);
    return {1'b1, IW'(w), (s >= (1 << W)), W'(s % (1 << W))};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({gnt, sum, carry, rsp_id, rsp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b sum=%b c=%b id=%0d v=%b busy=%b, want all 0",
               gnt, sum, carry, rsp_id, rsp_valid, busy);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    tick();
    checks++;
    if ({gnt, rsp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL idle_no_req: got gnt=%b v=%b busy=%b, want 0", gnt, rsp_valid, busy);
    end
  endtask

  task automatic test_single();
    int w;
    logic [W-1:0] xa, xb;
    req = 4'b0100;
    a_bus = N*W'($urandom);
    b_bus = N*W'($urandom);
    a_bus[2*W +: W] = 2'b10;
    b_bus[2*W +: W] = 2'b11;
    rsp_ready = 1'b1;
    w = rr_winner(req, m_ptr);
    xa = op_of(a_bus, w);
    xb = op_of(b_bus, w);
    tick();
    checks++;
    if (gnt !== (N'(1) << w) || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt: got gnt=%b busy=%b, want gnt=%b busy=1", gnt, busy, N'(1) << w);
    end
    req = '0;
    a_bus = N*W'($urandom);
    b_bus = N*W'($urandom);
    tick();
    checks++;
    if ({rsp_valid, rsp_id, carry, sum} !== exp_rsp(w, xa, xb) || gnt !== '0) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%0d c=%b s=%b gnt=%b, want %b gnt=0",
               rsp_valid, rsp_id, carry, sum, gnt, exp_rsp(w, xa, xb));
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got v=%b busy=%b, want 0 0", rsp_valid, busy);
    end
    m_ptr = (w + 1) % N;
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int w;
    logic [W-1:0] xa, xb;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    req = '1;
    rsp_ready = 1'b1;
    a_bus = N*W'($urandom);
    b_bus = N*W'($urandom);
    for (int k = 0; k < 5; k++) begin
      w = rr_winner(req, m_ptr);
      xa = op_of(a_bus, w);
      xb = op_of(b_bus, w);
      tick();
      checks++;
      if (gnt !== (N'(1) << w)) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, N'(1) << w);
      end
      if (k == 4) req = '0;
      tick();
      checks++;
      if ({rsp_valid, rsp_id, carry, sum} !== exp_rsp(w, xa, xb)) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: got v=%b id=%0d c=%b s=%b want %b",
                 k, rsp_valid, rsp_id, carry, sum, exp_rsp(w, xa, xb));
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || gnt !== '0) begin
        errors++;
        $display("FAIL rr_gap[%0d]: got v=%b gnt=%b want 0", k, rsp_valid, gnt);
      end
      m_ptr = (w + 1) % N;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int w, w2;
    logic [W-1:0] xa, xb;
    logic [IW+W+1:0] e;
    logic bad;
    req = 4'b0011;
    rsp_ready = 1'b0;
    a_bus = N*W'($urandom);
    b_bus = N*W'($urandom);
    w = rr_winner(req, m_ptr);
    xa = op_of(a_bus, w);
    xb = op_of(b_bus, w);
    e = exp_rsp(w, xa, xb);
    tick();
    checks++;
    if (gnt !== (N'(1) << w)) begin
      errors++;
      $display("FAIL bp_gnt: got %b want %b", gnt, N'(1) << w);
    end
    req[w] = 1'b0;
    tick();
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if ({rsp_valid, rsp_id, carry, sum} !== e || gnt !== '0) bad = 1'b1;
      if (k < 5) begin
        a_bus[w*W +: W] = W'($urandom);
        tick();
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got v=%b id=%0d c=%b s=%b gnt=%b want %b gnt=0",
               rsp_valid, rsp_id, carry, sum, gnt, e);
    end
    rsp_ready = 1'b1;
    tick();
    m_ptr = (w + 1) % N;
    checks++;
    if (rsp_valid !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL bp_accept: got v=%b gnt=%b want 0", rsp_valid, gnt);
    end
    w2 = rr_winner(req, m_ptr);
    tick();
    checks++;
    if (gnt !== (N'(1) << w2)) begin
      errors++;
      $display("FAIL bp_next_gnt: got %b want %b", gnt, N'(1) << w2);
    end
    req = '0;
    tick();
    tick();
    m_ptr = (w2 + 1) % N;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    int w;
    logic [W-1:0] xa, xb;
    req = 4'b1000;
    rsp_ready = 1'b1;
    w = rr_winner(req, m_ptr);
    tick();
    checks++;
    if (gnt !== (N'(1) << w)) begin
      errors++;
      $display("FAIL rst_exec_gnt: got %b want %b", gnt, N'(1) << w);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, sum, carry, rsp_id, rsp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL rst_exec_async: got gnt=%b s=%b c=%b id=%0d v=%b busy=%b want all 0",
               gnt, sum, carry, rsp_id, rsp_valid, busy);
    end
    m_ptr = 0;
    tick();
    tick();
    rst_n = 1'b1;
    req = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_exec_no_rsp: got v=%b busy=%b want 0", rsp_valid, busy);
    end
    req = 4'b1001;
    a_bus = N*W'($urandom);
    b_bus = N*W'($urandom);
    w = rr_winner(req, m_ptr);
    xa = op_of(a_bus, w);
    xb = op_of(b_bus, w);
    tick();
    checks++;
    if (gnt !== (N'(1) << w)) begin
      errors++;
      $display("FAIL rst_exec_ptr0: got %b want %b", gnt, N'(1) << w);
    end
    req = '0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, carry, sum} !== exp_rsp(w, xa, xb)) begin
      errors++;
      $display("FAIL rst_exec_rsp: got v=%b id=%0d c=%b s=%b want %b",
               rsp_valid, rsp_id, carry, sum, exp_rsp(w, xa, xb));
    end
    tick();
    m_ptr = (w + 1) % N;
    rsp_ready = 1'b0;
  endtask

  task automatic test_drop();
    int w;
    logic bad;
    req = 4'b0001;
    rsp_ready = 1'b0;
    w = rr_winner(req, m_ptr);
    tick();
    req = 4'b0010;
    tick();
    rsp_ready = 1'b1;
    tick();
    m_ptr = (w + 1) % N;
    req = '0;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (gnt !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL drop_no_gnt: got gnt=%b busy=%b want 0 0", gnt, busy);
    end
    req = 4'b0010;
    a_bus[1*W +: W] = 2'b01;
    b_bus[1*W +: W] = 2'b01;
    w = rr_winner(req, m_ptr);
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL drop_regnt: got %b want 0010", gnt);
    end
    req = '0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, carry, sum} !== exp_rsp(w, 2'b01, 2'b01)) begin
      errors++;
      $display("FAIL drop_rsp: got v=%b id=%0d c=%b s=%b want %b",
               rsp_valid, rsp_id, carry, sum, exp_rsp(w, 2'b01, 2'b01));
    end
    tick();
    m_ptr = (w + 1) % N;
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int w;
    int order [3];
    req = 4'b1001;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = rr_winner(req, m_ptr);
      order[k] = w;
      tick();
      checks++;
      if (gnt !== (N'(1) << w)) begin
        errors++;
        $display("FAIL wrap_gnt[%0d]: got %b want %b", k, gnt, N'(1) << w);
      end
      if (k == 2) req = '0;
      tick();
      tick();
      m_ptr = (w + 1) % N;
    end
    checks++;
    if (order[0] != 3 || order[1] != 0 || order[2] != 3) begin
      errors++;
      $display("FAIL wrap_order: got %0d,%0d,%0d want 3,0,3", order[0], order[1], order[2]);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    int w, stall;
    logic [W-1:0] xa, xb;
    logic [IW+W+1:0] e;
    for (int op = 0; op < 40; op++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        tick();
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle[%0d]: got gnt=%b busy=%b want 0", op, gnt, busy);
        end
      end
      req = N'($urandom_range(1, (1 << N) - 1));
      a_bus = N*W'($urandom);
      b_bus = N*W'($urandom);
      rsp_ready = 1'($urandom);
      w = rr_winner(req, m_ptr);
      xa = op_of(a_bus, w);
      xb = op_of(b_bus, w);
      e = exp_rsp(w, xa, xb);
      tick();
      checks++;
      if (gnt !== (N'(1) << w)) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: got %b want %b", op, gnt, N'(1) << w);
      end
      req = N'($urandom);
      a_bus = N*W'($urandom);
      b_bus = N*W'($urandom);
      rsp_ready = 1'($urandom);
      tick();
      stall = $urandom_range(0, 3);
      for (int k = 0; k <= stall; k++) begin
        checks++;
        if ({rsp_valid, rsp_id, carry, sum} !== e || gnt !== '0) begin
          errors++;
          $display("FAIL rand_rsp[%0d.%0d]: got v=%b id=%0d c=%b s=%b gnt=%b want %b",
                   op, k, rsp_valid, rsp_id, carry, sum, gnt, e);
        end
        rsp_ready = (k == stall);
        req = N'($urandom);
        a_bus = N*W'($urandom);
        tick();
      end
      m_ptr = (w + 1) % N;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_accept[%0d]: got v=%b busy=%b want 0 0", op, rsp_valid, busy);
      end
    end
    req = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    test_wrap();
    test_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_2bit_rr_ctrl.md
Name: add_2bit_rr_ctrl

Overview:
Shares one registered W-bit adder datapath among NUM_REQ requesters.
- Picks one pending request by round-robin, captures its operands and runs the add.
- Returns sum, carry and requester ID over a valid/ready response channel.
- Sits between the client blocks and the adder datapath; the only path by which clients reach the adder.

Parameters:
NUM_REQ, 4, number of requesters (2..16, need not be a power of two)
WIDTH, 2, operand width in bits
ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden)

Ports:
clk_in  input  1  clock, all state on rising edge
rst_n_in  input  1  asynchronous active-low reset
req_in  input  NUM_REQ  per-requester request level
a_in  input  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
b_in  input  NUM_REQ*WIDTH  packed operand B, same packing
gnt_out  output  NUM_REQ  one-hot grant pulse, 1 cycle, operands captured
sum_out  output  WIDTH  low WIDTH bits of a+b
carry_out  output  1  bit WIDTH of a+b
rsp_id_out  output  ID_W  index of requester owning the response
rsp_valid_out  output  1  response valid
rsp_ready_in  input  1  response consumer ready
busy_out  output  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0. Asynchronous assert, synchronous release. An in-flight op is discarded, with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If |req_in at a clock edge: the winner is the first set req_in bit searching from ptr upward, wrapping NUM_REQ-1 -> 0.
  - Registered on that edge: operands, winner ID, gnt_out = onehot(winner) for exactly one cycle.
  - Next state EXEC. If no request, stay IDLE.
- EXEC:
  - On the edge: {carry_out, sum_out} <= a_cap + b_cap, zero-extended to WIDTH+1 bits.
  - rsp_id_out <= winner; rsp_valid_out <= 1; next state RESP.
  - gnt_out returns to 0.
- RESP:
  - rsp_valid_out, sum_out, carry_out and rsp_id_out are held stable until the edge where rsp_ready_in = 1.
  - On that edge: rsp_valid_out <= 0, ptr <= (winner == NUM_REQ-1) ? 0 : winner+1, next state IDLE.
  - rsp_ready_in asserted before valid has no effect.
- Latency: request sampled at edge k -> gnt_out high during k..k+1 -> rsp_valid_out high from edge k+1. Best-case throughput is one op per 3 cycles.
- Arbitration happens only in IDLE. Requests arriving during EXEC/RESP wait and are not lost while held.
- Requester contract:
  - Hold req_in and operands until gnt_out.
  - Operands are sampled only at the grant edge; later changes are ignored.
  - A req_in dropped before grant is never served.
  - req_in still high in the cycle after gnt is a new request.
- sum_out, carry_out and rsp_id_out retain their last values when rsp_valid_out = 0 (0 after reset). Consumers must qualify them with valid.
- Unused FSM encoding recovers to IDLE.

Decomposition:
- Package add_ctrl_pkg: FSM state encoding (IDLE = 0, EXEC = 1, RESP = 2), default NUM_REQ/WIDTH constants, ID width function.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: any, winner index, one-hot.
  - Instantiated once.
- The adder is inline arithmetic in the top block.

Test Plan:
1. Single requester 2, a = 2'b10, b = 2'b11, ready tied 1 -> gnt_out = 4'b0100 for 1 cycle; next cycle rsp_valid = 1, sum = 2'b01, carry = 1, id = 2; back to IDLE.
2. All four requests held continuously, ready = 1 -> grants in order 0, 1, 2, 3, 0, each 3 cycles apart; ptr wraps 3 -> 0.
3. Backpressure: rsp_ready low for 5 cycles with req_in = 4'b0011 pending -> rsp_valid, sum, carry and id constant; no gnt until one cycle after ready is accepted.
4. Async reset pulse while in EXEC -> all outputs 0 immediately; no response for the aborted op; ptr = 0, so req 0 wins over req 3 next.
5. Req 1 dropped the cycle before a possible grant while the block is busy -> no gnt_out[1]; req 1 raised again later with a = 1, b = 1 -> sum = 2'b10, carry = 0, id = 1.
6. After serving requester 3 with req_in = 4'b1001 -> requester 0 granted next (wrap), then requester 3.
